// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command receiver: legal opcodes and FSM state encoding.
package spi_cmd_pkg;

  localparam logic [2:0] OP_WRITE = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b010;

  localparam int         ST_W     = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous level, with one-clk rise/fall pulses
// derived from the synchronised level.
module spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the raw input through the synchroniser and keep one extra copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI command receiver: collects {op, addr, data} frames MSB first and applies
// WRITE / ADD / CLEAR to an addressed register bank, flagging illegal opcodes.
module spi_cmd_rx
  import spi_cmd_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int SAMPLE_EDGE = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sclk,
  input  logic                             ss,
  input  logic                             mosi,
  output logic [(2**ADDR_W)*DATA_W-1:0]    result,
  output logic                             upd_valid,
  output logic [ADDR_W-1:0]                upd_addr,
  output logic                             err,
  output logic                             busy
);

  localparam int NUM_REG = 2**ADDR_W;
  localparam int FRAME_W = OP_W + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [OP_W-1:0]  OPC_WRITE  = OP_W'(OP_WRITE);
  localparam logic [OP_W-1:0]  OPC_ADD    = OP_W'(OP_ADD);
  localparam logic [OP_W-1:0]  OPC_CLEAR  = OP_W'(OP_CLEAR);

  logic                    sclk_level_unused;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    ss_s;
  logic                    ss_rise_unused;
  logic                    ss_fall;
  logic [SYNC_STAGES-1:0]  mosi_chain;
  logic                    mosi_s;
  logic                    strobe;

  logic [ST_W-1:0]         state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_W-1:0]      shreg;

  logic [OP_W-1:0]         op_f;
  logic [ADDR_W-1:0]       addr_f;
  logic [DATA_W-1:0]       data_f;
  logic [DATA_W-1:0]       reg_cur;
  logic [DATA_W-1:0]       reg_sum;

  spi_edge_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (sclk),
    .sync_out (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // ss idles high, so the synchroniser resets to 1 to avoid a spurious frame start
  spi_edge_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ss_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (ss),
    .sync_out (ss_s),
    .rise     (ss_rise_unused),
    .fall     (ss_fall)
  );

  // mosi only needs the level path, delayed to line up with the synced sclk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_chain[SYNC_STAGES-1];
  assign strobe = ((SAMPLE_EDGE != 0) ? sclk_rise : sclk_fall) & ~ss_s;

  // Frame FSM: wait for ss, shift in FRAME_W bits, execute once, then sit out the rest of the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (ss_fall) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ss_s) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else if (strobe) begin
            shreg   <= {shreg[FRAME_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == FRAME_LAST) begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ss_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_f    = shreg[FRAME_W-1 -: OP_W];
  assign addr_f  = shreg[DATA_W +: ADDR_W];
  assign data_f  = shreg[DATA_W-1:0];
  assign reg_cur = result[addr_f*DATA_W +: DATA_W];
  assign reg_sum = reg_cur + data_f;

  // Decode the captured frame in ST_EXEC and commit to the addressed register, or flag an error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      upd_valid <= 1'b0;
      upd_addr  <= '0;
      err       <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      err       <= 1'b0;
      if (state == ST_EXEC) begin
        case (op_f)
          OPC_WRITE: begin
            result[addr_f*DATA_W +: DATA_W] <= data_f;
            upd_valid                       <= 1'b1;
            upd_addr                        <= addr_f;
          end
          OPC_ADD: begin
            result[addr_f*DATA_W +: DATA_W] <= reg_sum;
            upd_valid                       <= 1'b1;
            upd_addr                        <= addr_f;
          end
          OPC_CLEAR: begin
            result[addr_f*DATA_W +: DATA_W] <= '0;
            upd_valid                       <= 1'b1;
            upd_addr                        <= addr_f;
          end
          default: begin
            err <= 1'b1;
          end
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Bench for spi_cmd_rx: one falling-edge and one rising-edge instance share the SPI pins;
// a reference register model pushes expected commits that a monitor checks per instance.
module tb_spi_cmd_rx;

  localparam int H      = 6;
  localparam int STAGES = 2;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  addr;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        ss;
  logic        mosi;

  logic [31:0] result0, result1;
  logic        upd_valid0, upd_valid1;
  logic [1:0]  upd_addr0, upd_addr1;
  logic        err0, err1;
  logic        busy0, busy1;

  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  int          pulse_cnt [2];
  exp_t        sbq [2][$];
  logic [7:0]  model_regs [4];
  logic [1:0]  model_addr;

  spi_cmd_rx #(.SAMPLE_EDGE(0), .SYNC_STAGES(STAGES)) dut_fall (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .result    (result0),
    .upd_valid (upd_valid0),
    .upd_addr  (upd_addr0),
    .err       (err0),
    .busy      (busy0)
  );

  spi_cmd_rx #(.SAMPLE_EDGE(1), .SYNC_STAGES(STAGES)) dut_rise (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .result    (result1),
    .upd_valid (upd_valid1),
    .upd_addr  (upd_addr1),
    .err       (err1),
    .busy      (busy1)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Runaway guard
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelSnapshot();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  task automatic resetModel();
    for (int r = 0; r < 4; r++) model_regs[r] = 8'h00;
    model_addr = 2'd0;
    sbq[0].delete();
    sbq[1].delete();
  endtask

  task automatic modelFrame(input logic [2:0] op, input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    case (op)
      3'b100: begin model_regs[a] = d;                 model_addr = a; end
      3'b110: begin model_regs[a] = model_regs[a] + d; model_addr = a; end
      3'b010: begin model_regs[a] = 8'h00;             model_addr = a; end
      default: e.is_err = 1'b1;
    endcase
    e.addr = model_addr;
    e.res  = modelSnapshot();
    sbq[0].push_back(e);
    sbq[1].push_back(e);
  endtask

  task automatic scoreDut(input int d, input logic uv, input logic er,
                          input logic [31:0] res, input logic [1:0] a);
    exp_t e;
    if (!(uv || er)) return;
    pulse_cnt[d]++;
    if (sbq[d].size() == 0) begin
      checkOutput($sformatf("dut%0d unexpected strobe", d), {62'd0, uv, er}, 64'd0);
      return;
    end
    e = sbq[d].pop_front();
    checkOutput($sformatf("dut%0d err", d), er, e.is_err);
    checkOutput($sformatf("dut%0d upd_valid", d), uv, !e.is_err);
    checkOutput($sformatf("dut%0d result", d), res, e.res);
    checkOutput($sformatf("dut%0d upd_addr", d), a, e.addr);
  endtask

  // Commit monitor for both instances, sampled just after each rising clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      scoreDut(0, upd_valid0, err0, result0, upd_addr0);
      scoreDut(1, upd_valid1, err1, result1, upd_addr1);
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits of {op,addr,data} (zeros past bit 13) in one ss-low window
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] a, input logic [7:0] d,
                               input int nbits, input bit chk_lat);
    logic [12:0] frame;
    logic [4:0]  lat;
    frame = {op, a, d};
    @(negedge clk);
    ss = 1'b0;
    waitClk(H);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 13) ? frame[12-i] : 1'b0;
      if (i == 12) modelFrame(op, a, d);
      waitClk(H);
      sclk = 1'b1;
      waitClk(H);
      sclk = 1'b0;
      if (i == 12 && chk_lat) begin
        lat = '0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          lat[k] = upd_valid0 | err0;
        end
        checkOutput("commit latency", lat, 5'b01000);
        @(negedge clk);
      end
      waitClk(H);
    end
    ss = 1'b1;
    waitClk(2*H);
  endtask

  initial begin
    int before0, before1;
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    rst  = 1'b1;
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    resetModel();
    waitClk(5);
    checkOutput("reset result", result0, 32'h0);
    checkOutput("reset busy", busy0, 1'b0);
    rst = 1'b0;
    waitClk(5);

    // reset in the middle of a frame, after a register already holds data
    applyStimulus(3'b100, 2'd1, 8'h77, 13, 1'b0);
    checkOutput("pre-reset result", result0, 32'h0000_7700);
    ss = 1'b0;
    waitClk(H);
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      waitClk(H); sclk = 1'b1; waitClk(H); sclk = 1'b0; waitClk(H);
    end
    checkOutput("mid-frame busy", busy0, 1'b1);
    rst = 1'b1;
    resetModel();
    waitClk(2);
    checkOutput("rst result0", result0, 32'h0);
    checkOutput("rst result1", result1, 32'h0);
    checkOutput("rst upd_valid", upd_valid0, 1'b0);
    checkOutput("rst err", err0, 1'b0);
    checkOutput("rst busy", busy0, 1'b0);
    checkOutput("rst upd_addr", upd_addr0, 2'd0);
    ss   = 1'b1;
    sclk = 1'b0;
    waitClk(3);
    rst = 1'b0;
    waitClk(H);

    // WRITE 0xA5 to reg 2
    before0 = pulse_cnt[0];
    applyStimulus(3'b100, 2'd2, 8'hA5, 13, 1'b1);
    checkOutput("write result", result0, 32'h00A5_0000);
    checkOutput("write upd_addr", upd_addr0, 2'd2);
    checkOutput("write pulses", pulse_cnt[0] - before0, 1);

    // ADD 0x6A wraps to 0x0F
    before0 = pulse_cnt[0];
    applyStimulus(3'b110, 2'd2, 8'h6A, 13, 1'b1);
    checkOutput("add result", result0, 32'h000F_0000);
    checkOutput("add pulses", pulse_cnt[0] - before0, 1);

    // CLEAR ignores data, then an illegal opcode only raises err
    applyStimulus(3'b010, 2'd2, 8'hFF, 13, 1'b0);
    checkOutput("clear result", result0, 32'h0);
    before0 = pulse_cnt[0];
    applyStimulus(3'b111, 2'd1, 8'h01, 13, 1'b1);
    checkOutput("illegal result", result0, 32'h0);
    checkOutput("illegal upd_addr", upd_addr0, 2'd2);
    checkOutput("illegal pulses", pulse_cnt[0] - before0, 1);

    // abort after 7 bits, then a full WRITE to reg 0
    before0 = pulse_cnt[0];
    before1 = pulse_cnt[1];
    applyStimulus(3'b100, 2'd0, 8'h99, 7, 1'b0);
    checkOutput("abort pulses0", pulse_cnt[0] - before0, 0);
    checkOutput("abort pulses1", pulse_cnt[1] - before1, 0);
    checkOutput("abort busy", busy0, 1'b0);
    checkOutput("abort result", result0, 32'h0);
    applyStimulus(3'b100, 2'd0, 8'h3C, 13, 1'b1);
    checkOutput("post-abort result", result0, 32'h0000_003C);

    // 16 clocks in one window: only the first 13 bits commit
    before0 = pulse_cnt[0];
    before1 = pulse_cnt[1];
    applyStimulus(3'b100, 2'd3, 8'h11, 16, 1'b0);
    checkOutput("extra clk result0", result0, 32'h1100_003C);
    checkOutput("extra clk result1", result1, 32'h1100_003C);
    checkOutput("extra clk pulses0", pulse_cnt[0] - before0, 1);
    checkOutput("extra clk pulses1", pulse_cnt[1] - before1, 1);
    checkOutput("extra clk upd_addr1", upd_addr1, 2'd3);

    waitClk(10);
    checkOutput("dut0 pending commits", sbq[0].size(), 0);
    checkOutput("dut1 pending commits", sbq[1].size(), 0);
    checkOutput("final busy", busy1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
